accum_ctrl: RTL

- Control sequencer for the lab-3 switch accumulator datapath (10-bit operand, 17-bit accumulator register, external adder).
- Converts raw active-low Run and Clear pushbuttons into clean single-cycle commands, and captures the switch operand.
- Issues exactly one accumulator load per button press.
- Keeps a press counter and a sticky carry/overflow flag for the LEDs.

---
 rtl/accum_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/accum_ctrl.sv
// Control sequencer for the switch accumulator: synchronizes and debounces the Run/Clear
// buttons, issues one load or clear pulse per press, and tracks a press count and an overflow flag.
module accum_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OP_W            = 10,
  parameter int CNT_W           = 8
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Run_n,
  input  logic            Clear_n,
  input  logic [OP_W-1:0] SW,
  input  logic            Carry_In,
  output logic [OP_W-1:0] Operand,
  output logic            Load_Reg,
  output logic            Clear_Reg,
  output logic            Busy,
  output logic [CNT_W-1:0] Acc_Count,
  output logic            Overflow
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_REL = 2'd2,
    CLR      = 2'd3
  } state_t;

  // Button vectors: bit 0 = Run, bit 1 = Clear (all levels active-low)
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         stable_q, stable_d, stable_prev_q;
  logic [1:0]         ev_q, ev_d;
  logic [1:0][DW-1:0] cnt_q, cnt_d;

  state_t             state_q, state_d;
  logic [OP_W-1:0]    operand_q, operand_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               clear_pend_q, clear_pend_d;
  logic               run_held_s;

  // Synchronizer, debounce and press-event registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q       <= 2'b11;
      sync2_q       <= 2'b11;
      stable_q      <= 2'b11;
      stable_prev_q <= 2'b11;
      ev_q          <= 2'b00;
      cnt_q         <= '0;
    end else begin
      sync1_q       <= {Clear_n, Run_n};
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      ev_q          <= ev_d;
      cnt_q         <= cnt_d;
    end
  end

  // Debounce: any agreeing sample restarts the count, so only an unbroken run is accepted
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i]    = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    ev_d = stable_prev_q & ~stable_q;
  end

  assign run_held_s = ~stable_q[0];

  // FSM and datapath registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      operand_q    <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      clear_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      operand_q    <= operand_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      clear_pend_q <= clear_pend_d;
    end
  end

  // Next-state logic; a Clear request always takes priority over Run
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clear_pend_q || ev_q[1]) begin
          state_d = CLR;
        end else if (ev_q[0]) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (clear_pend_q) begin
          state_d = CLR;
        end else if (!run_held_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_REL;
        end
      end
      CLR: begin
        if (run_held_s) begin
          state_d = WAIT_REL;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values: operand capture, saturating count, sticky overflow, pending clear
  always_comb begin
    operand_d    = operand_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    clear_pend_d = clear_pend_q | ev_q[1];
    if (state_q == IDLE && state_d == LOAD) begin
      operand_d = SW;
    end else begin
      operand_d = operand_q;
    end
    if (state_q == LOAD) begin
      if (acc_q != {CNT_W{1'b1}}) begin
        acc_d = acc_q + 1'b1;
      end else begin
        acc_d = acc_q;
      end
      ovf_d = ovf_q | Carry_In;
    end else if (state_q == CLR) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else begin
      acc_d = acc_q;
      ovf_d = ovf_q;
    end
    if (state_q != CLR && state_d == CLR) begin
      clear_pend_d = 1'b0;
    end else begin
      clear_pend_d = clear_pend_q | ev_q[1];
    end
  end

  // Outputs decoded from registers only
  always_comb begin
    Load_Reg  = 1'b0;
    Clear_Reg = 1'b0;
    case (state_q)
      LOAD:    Load_Reg  = 1'b1;
      CLR:     Clear_Reg = 1'b1;
      default: begin
        Load_Reg  = 1'b0;
        Clear_Reg = 1'b0;
      end
    endcase
    Busy      = (state_q != IDLE);
    Operand   = operand_q;
    Acc_Count = acc_q;
    Overflow  = ovf_q;
  end

endmodule
